// File: rtl/mips_core.sv
// mips_core: single-cycle MIPS-I integer subset with private instruction memory, data memory and register file.
// One instruction retires per clk; PC, registers and data memory reset asynchronously, instruction memory never does.

module mips_pc (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] next_i,
  output logic [31:0] pc_o
);
  logic [31:0] OUT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) OUT <= '0;
    else        OUT <= next_i;
  end

  assign pc_o = OUT;
endmodule

module mips_imem #(
  parameter int WORDS = 256,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          load_we_i,
  input  logic [AW-1:0] load_addr_i,
  input  logic [31:0]   load_data_i,
  input  logic [AW-1:0] addr_i,
  output logic [31:0]   data_o
);
  logic [31:0] InstructionMemory [0:WORDS-1];

  // Load port exists for image preload; the core ties it off.
  always_ff @(posedge clk) begin
    if (load_we_i) InstructionMemory[load_addr_i] <= load_data_i;
  end

  assign data_o = InstructionMemory[addr_i];
endmodule

module mips_regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  ra_i,
  input  logic [4:0]  rb_i,
  output logic [31:0] ra_data_o,
  output logic [31:0] rb_data_o,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i
);
  logic [31:0] Registers [0:31];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) Registers[i] <= '0;
    end else if (we_i && (waddr_i != 5'd0)) begin
      Registers[waddr_i] <= wdata_i;
    end
  end

  assign ra_data_o = (ra_i == 5'd0) ? 32'd0 : Registers[ra_i];
  assign rb_data_o = (rb_i == 5'd0) ? 32'd0 : Registers[rb_i];
endmodule

module mips_dmem #(
  parameter int WORDS = 256,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] addr_i,
  input  logic          we_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);
  logic [31:0] DataMemory [0:WORDS-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WORDS; i++) DataMemory[i] <= '0;
    end else if (we_i) begin
      DataMemory[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = DataMemory[addr_i];
endmodule

module mips_core #(
  parameter int IMEM_WORDS = 256,
  parameter int DMEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] pc
);
  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_WORDS);

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J     = 6'h02, OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE   = 6'h05, OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09, OP_SLTI  = 6'h0A, OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C, OP_ORI   = 6'h0D, OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F, OP_LW    = 6'h23, OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08, FN_ADD  = 6'h20, FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22, FN_SUBU = 6'h23, FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25, FN_XOR  = 6'h26, FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A, FN_SLTU = 6'h2B;

  logic [31:0] pc_q, pc_d, pc_plus4, instr;
  logic [31:0] rs_val, rt_val, sext, zext, mem_addr, dm_rdata;
  logic [31:0] rf_wdata;
  logic [4:0]  rf_waddr;
  logic        rf_we, dm_we;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [25:0] target;

  mips_pc ProgCounter (
    .clk    (clk),
    .rst_n  (rst_n),
    .next_i (pc_d),
    .pc_o   (pc_q)
  );

  mips_imem #(.WORDS(IMEM_WORDS)) IM (
    .clk         (clk),
    .load_we_i   (1'b0),
    .load_addr_i ({IAW{1'b0}}),
    .load_data_i (32'd0),
    .addr_i      (pc_q[IAW+1:2]),
    .data_o      (instr)
  );

  mips_regfile RF (
    .clk       (clk),
    .rst_n     (rst_n),
    .ra_i      (rs),
    .rb_i      (rt),
    .ra_data_o (rs_val),
    .rb_data_o (rt_val),
    .we_i      (rf_we),
    .waddr_i   (rf_waddr),
    .wdata_i   (rf_wdata)
  );

  mips_dmem #(.WORDS(DMEM_WORDS)) DM (
    .clk     (clk),
    .rst_n   (rst_n),
    .addr_i  (mem_addr[DAW+1:2]),
    .we_i    (dm_we),
    .wdata_i (rt_val),
    .rdata_o (dm_rdata)
  );

  assign op     = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign shamt  = instr[10:6];
  assign funct  = instr[5:0];
  assign imm    = instr[15:0];
  assign target = instr[25:0];

  assign sext     = {{16{imm[15]}}, imm};
  assign zext     = {16'd0, imm};
  assign pc_plus4 = pc_q + 32'd4;
  assign mem_addr = rs_val + sext;
  assign pc       = pc_q;

  // Anything not decoded below falls through as a NOP: PC+4, no writes.
  always_comb begin
    pc_d     = pc_plus4;
    rf_we    = 1'b0;
    rf_waddr = rt;
    rf_wdata = 32'd0;
    dm_we    = 1'b0;
    case (op)
      OP_RTYPE: begin
        rf_waddr = rd;
        rf_we    = 1'b1;
        case (funct)
          FN_ADD, FN_ADDU: rf_wdata = rs_val + rt_val;
          FN_SUB, FN_SUBU: rf_wdata = rs_val - rt_val;
          FN_AND:          rf_wdata = rs_val & rt_val;
          FN_OR:           rf_wdata = rs_val | rt_val;
          FN_XOR:          rf_wdata = rs_val ^ rt_val;
          FN_NOR:          rf_wdata = ~(rs_val | rt_val);
          FN_SLT:          rf_wdata = {31'd0, $signed(rs_val) < $signed(rt_val)};
          FN_SLTU:         rf_wdata = {31'd0, rs_val < rt_val};
          FN_SLL:          rf_wdata = rt_val << shamt;
          FN_SRL:          rf_wdata = rt_val >> shamt;
          FN_SRA:          rf_wdata = $unsigned($signed(rt_val) >>> shamt);
          FN_JR: begin
            rf_we = 1'b0;
            pc_d  = rs_val;
          end
          default:         rf_we = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin rf_we = 1'b1; rf_wdata = rs_val + sext; end
      OP_SLTI:  begin rf_we = 1'b1; rf_wdata = {31'd0, $signed(rs_val) < $signed(sext)}; end
      OP_SLTIU: begin rf_we = 1'b1; rf_wdata = {31'd0, rs_val < sext}; end
      OP_ANDI:  begin rf_we = 1'b1; rf_wdata = rs_val & zext; end
      OP_ORI:   begin rf_we = 1'b1; rf_wdata = rs_val | zext; end
      OP_XORI:  begin rf_we = 1'b1; rf_wdata = rs_val ^ zext; end
      OP_LUI:   begin rf_we = 1'b1; rf_wdata = {imm, 16'd0}; end
      OP_LW:    begin rf_we = 1'b1; rf_wdata = dm_rdata; end
      OP_SW:    dm_we = 1'b1;
      OP_BEQ:   if (rs_val == rt_val) pc_d = pc_plus4 + {sext[29:0], 2'b00};
      OP_BNE:   if (rs_val != rt_val) pc_d = pc_plus4 + {sext[29:0], 2'b00};
      OP_J:     pc_d = {pc_plus4[31:28], target, 2'b00};
      OP_JAL: begin
        pc_d     = {pc_plus4[31:28], target, 2'b00};
        rf_we    = 1'b1;
        rf_waddr = 5'd31;
        rf_wdata = pc_plus4;
      end
      default: ;
    endcase
  end

  logic unused_bits;
  assign unused_bits = ^{pc_q[1:0], pc_q[31:IAW+2], mem_addr[1:0], mem_addr[31:DAW+2]};
endmodule

// File: tb/tb_mips_core.sv
// Directed bench for mips_core: table of single-instruction ALU vectors plus hand-built
// programs for memory, control flow, division loop, reset and NOP corner cases.

module tb_mips_core;
  logic        clk;
  logic        rst_n;
  logic [31:0] pc;

  int checks = 0;
  int errors = 0;

  mips_core dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pc    (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [4:0] R0 = 5'd0, V0 = 5'd2, V1 = 5'd3, A0 = 5'd4, A1 = 5'd5;
  localparam logic [4:0] T0 = 5'd8, T1 = 5'd9, T2 = 5'd10, RA = 5'd31;

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] jtype(input logic [5:0] op, input logic [25:0] tgt);
    return {op, tgt};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic load_prog(input logic [31:0] p[$]);
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 256; i++)
      dut.IM.InstructionMemory[i] <= (i < p.size()) ? p[i] : 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [31:0] reg_rd(input logic [4:0] r);
    return dut.RF.Registers[r];
  endfunction

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] exp;
  } alu_vec_t;

  alu_vec_t    vecs[$];
  logic [31:0] prog[$];
  logic [31:0] acc;

  initial begin
    rst_n = 1'b0;

    // $t0 = 7, $t1 = -3 precede each vector; the vector writes $t2.
    vecs.push_back('{name:"add",   instr:rtype(T0, T1, T2, 5'd0, 6'h20), exp:32'h0000_0004});
    vecs.push_back('{name:"addu",  instr:rtype(T0, T1, T2, 5'd0, 6'h21), exp:32'h0000_0004});
    vecs.push_back('{name:"sub",   instr:rtype(T0, T1, T2, 5'd0, 6'h22), exp:32'h0000_000A});
    vecs.push_back('{name:"subu",  instr:rtype(T1, T0, T2, 5'd0, 6'h23), exp:32'hFFFF_FFF6});
    vecs.push_back('{name:"slt",   instr:rtype(T1, T0, T2, 5'd0, 6'h2A), exp:32'h0000_0001});
    vecs.push_back('{name:"sltu",  instr:rtype(T1, T0, T2, 5'd0, 6'h2B), exp:32'h0000_0000});
    vecs.push_back('{name:"and",   instr:rtype(T0, T1, T2, 5'd0, 6'h24), exp:32'h0000_0005});
    vecs.push_back('{name:"or",    instr:rtype(T0, T1, T2, 5'd0, 6'h25), exp:32'hFFFF_FFFF});
    vecs.push_back('{name:"xor",   instr:rtype(T0, T1, T2, 5'd0, 6'h26), exp:32'hFFFF_FFFA});
    vecs.push_back('{name:"nor",   instr:rtype(T0, T1, T2, 5'd0, 6'h27), exp:32'h0000_0000});
    vecs.push_back('{name:"sll",   instr:rtype(R0, T0, T2, 5'd2, 6'h00), exp:32'h0000_001C});
    vecs.push_back('{name:"srl",   instr:rtype(R0, T1, T2, 5'd4, 6'h02), exp:32'h0FFF_FFFF});
    vecs.push_back('{name:"sra",   instr:rtype(R0, T1, T2, 5'd1, 6'h03), exp:32'hFFFF_FFFE});
    vecs.push_back('{name:"addiu", instr:itype(6'h09, T0, T2, 16'hFFF8), exp:32'hFFFF_FFFF});
    vecs.push_back('{name:"slti",  instr:itype(6'h0A, T1, T2, 16'hFFFE), exp:32'h0000_0001});
    vecs.push_back('{name:"sltiu", instr:itype(6'h0B, T0, T2, 16'h0008), exp:32'h0000_0001});
    vecs.push_back('{name:"sltiu_big", instr:itype(6'h0B, T1, T2, 16'h0005), exp:32'h0000_0000});
    vecs.push_back('{name:"andi",  instr:itype(6'h0C, T1, T2, 16'hFFFF), exp:32'h0000_FFFD});
    vecs.push_back('{name:"ori",   instr:itype(6'h0D, T0, T2, 16'h8000), exp:32'h0000_8007});
    vecs.push_back('{name:"xori",  instr:itype(6'h0E, T1, T2, 16'h00FF), exp:32'hFFFF_FF02});
    vecs.push_back('{name:"lui",   instr:itype(6'h0F, R0, T2, 16'h8001), exp:32'h8001_0000});

    // Reset value before any edge is released.
    #2;
    check("reset_pc", pc, 32'd0);

    foreach (vecs[k]) begin
      prog = '{itype(6'h08, R0, T0, 16'd7), itype(6'h08, R0, T1, 16'hFFFD),
               vecs[k].instr, jtype(6'h02, 26'd3)};
      load_prog(prog);
      run(6);
      check({"alu_", vecs[k].name}, reg_rd(T2), vecs[k].exp);
      check({"alu_pc_", vecs[k].name}, pc, 32'd12);
    end

    // Store then load the same word.
    prog = '{itype(6'h0F, R0, T0, 16'h1234), itype(6'h0D, T0, T0, 16'h5678),
             itype(6'h2B, R0, T0, 16'd8), itype(6'h23, R0, T1, 16'd8),
             jtype(6'h02, 26'd4)};
    load_prog(prog);
    run(8);
    check("mem_lw", reg_rd(T1), 32'h1234_5678);
    check("mem_word2", dut.DM.DataMemory[2], 32'h1234_5678);
    check("mem_pc", pc, 32'd16);

    // Asynchronous reset mid-cycle, sampled before the next rising edge.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_pc", pc, 32'd0);
    check("async_pcreg", dut.ProgCounter.OUT, 32'd0);
    acc = '0;
    for (int r = 0; r < 32; r++) acc = acc | dut.RF.Registers[r];
    check("async_regs", acc, 32'd0);
    check("async_dmem", dut.DM.DataMemory[2], 32'd0);
    check("async_imem_kept", dut.IM.InstructionMemory[0], itype(6'h0F, R0, T0, 16'h1234));
    @(negedge clk);
    rst_n = 1'b1;
    run(1);
    check("restart_pc", pc, 32'd4);
    check("restart_t0", reg_rd(T0), 32'h1234_0000);
    run(4);
    check("restart_lw", reg_rd(T1), 32'h1234_5678);

    // Branches taken/not taken, jal/jr; skipped slots must stay zero.
    prog = '{itype(6'h08, R0, T0, 16'd1),    itype(6'h08, R0, T1, 16'd1),
             itype(6'h04, T0, T1, 16'd1),    itype(6'h08, R0, A0, 16'h55),
             itype(6'h04, T0, R0, 16'd1),    itype(6'h08, R0, A1, 16'h66),
             itype(6'h05, T0, R0, 16'd1),    itype(6'h08, R0, A0, 16'h77),
             jtype(6'h03, 26'd12),           itype(6'h08, R0, V1, 16'd9),
             jtype(6'h02, 26'd10),           32'd0,
             itype(6'h08, R0, V0, 16'd3),    rtype(RA, R0, R0, 5'd0, 6'h08)};
    load_prog(prog);
    run(15);
    check("ctl_skipped", reg_rd(A0), 32'd0);
    check("ctl_not_taken", reg_rd(A1), 32'h66);
    check("ctl_ra", reg_rd(RA), 32'd36);
    check("ctl_callee", reg_rd(V0), 32'd3);
    check("ctl_return", reg_rd(V1), 32'd9);
    check("ctl_pc", pc, 32'd40);

    // 100 / 7 by repeated subtraction.
    prog = '{itype(6'h08, R0, A0, 16'd100), itype(6'h08, R0, A1, 16'd7),
             itype(6'h08, R0, V0, 16'd0),   itype(6'h08, A0, V1, 16'd0),
             rtype(V1, A1, T0, 5'd0, 6'h2A), itype(6'h05, T0, R0, 16'd3),
             rtype(V1, A1, V1, 5'd0, 6'h22), itype(6'h08, V0, V0, 16'd1),
             jtype(6'h02, 26'd4),           jtype(6'h02, 26'd9)};
    load_prog(prog);
    run(100);
    check("div_quot", reg_rd(V0), 32'h0000_000E);
    check("div_rem", reg_rd(V1), 32'h0000_0002);
    check("div_halt_pc", pc, 32'd36);
    run(5);
    check("div_halt_hold", pc, 32'd36);

    // $0 write discarded; undefined opcode and funct act as NOP.
    prog = '{itype(6'h08, R0, T0, 16'd7), itype(6'h08, R0, R0, 16'd5),
             32'hFD0A_1234, rtype(T0, T0, T2, 5'd0, 6'h3F), jtype(6'h02, 26'd4)};
    load_prog(prog);
    run(2);
    check("zero_reg", reg_rd(R0), 32'd0);
    check("zero_pc", pc, 32'd8);
    run(1);
    check("undef_op_pc", pc, 32'd12);
    check("undef_op_t2", reg_rd(T2), 32'd0);
    run(1);
    check("undef_fn_pc", pc, 32'd16);
    check("undef_fn_t2", reg_rd(T2), 32'd0);
    check("undef_t0", reg_rd(T0), 32'd7);

    // Fetch index wraps modulo IMEM_WORDS: PC 0x400 fetches word 0.
    prog = '{itype(6'h08, T1, T1, 16'd1), itype(6'h08, R0, T0, 16'h0400),
             rtype(T0, R0, R0, 5'd0, 6'h08)};
    load_prog(prog);
    run(3);
    check("wrap_pc", pc, 32'h0000_0400);
    check("wrap_t1_first", reg_rd(T1), 32'd1);
    run(1);
    check("wrap_pc_next", pc, 32'h0000_0404);
    check("wrap_t1_again", reg_rd(T1), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
